// File: rtl/spi_sclk_engine.sv
// SPI serial-clock engine: generates sclk/cs_n and per-bit shift/sample
// strobes for one frame of nbits bits, in any of the four SPI modes.
// Optional build macro SPI_SCLK_CS_GUARD_EN adds a div+1 cycle chip-select
// lead before the first edge and trail after the last edge.
// All outputs are registered; strobes change in the same cycle as sclk.
module spi_sclk_engine #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [CNT_WIDTH-1:0] nbits,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 shift_en,
  output logic                 sample_en,
  output logic                 busy,
  output logic                 done
);

`ifdef SPI_SCLK_CS_GUARD_EN
  typedef enum logic [2:0] {IDLE, LEAD, RUN, TRAIL, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, RUN, DONE} state_e;
`endif

  localparam logic [DIV_WIDTH-1:0] HCNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH:0]   ECNT_ONE = {{CNT_WIDTH{1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [CNT_WIDTH-1:0] nbits_q, nbits_d;
  logic [DIV_WIDTH-1:0] hcnt_q, hcnt_d;
  // One bit wider than nbits so 2*nbits edges never wrap.
  logic [CNT_WIDTH:0]   ecnt_q, ecnt_d;
  logic                 sclk_q, sclk_d;
  logic                 cs_n_q, cs_n_d;
  logic                 shift_q, shift_d;
  logic                 sample_q, sample_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_WIDTH:0]   total_edges;
  logic                 hcnt_hit;
  logic                 lead_edge;
  logic                 last_edge;

  assign total_edges = {nbits_q, 1'b0};
  assign hcnt_hit    = (hcnt_q == div_q);
  assign lead_edge   = ~ecnt_q[0];
  assign last_edge   = (ecnt_q == (total_edges - ECNT_ONE));

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d  = state_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    nbits_d  = nbits_q;
    hcnt_d   = hcnt_q;
    ecnt_d   = ecnt_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;
    busy_d   = busy_q;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        hcnt_d = '0;
        ecnt_d = '0;
        if (start) begin
          if (nbits != '0) begin
            cpol_d  = cpol;
            cpha_d  = cpha;
            div_d   = div;
            nbits_d = nbits;
            busy_d  = 1'b1;
            cs_n_d  = 1'b0;
`ifdef SPI_SCLK_CS_GUARD_EN
            state_d = LEAD;
`else
            state_d = RUN;
            shift_d = ~cpha;
`endif
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
`ifdef SPI_SCLK_CS_GUARD_EN
      LEAD: begin
        if (hcnt_hit) begin
          state_d = RUN;
          hcnt_d  = '0;
          shift_d = ~cpha_q;
        end else begin
          hcnt_d = hcnt_q + HCNT_ONE;
        end
      end
`endif
      RUN: begin
        if (ecnt_q == total_edges) begin
`ifdef SPI_SCLK_CS_GUARD_EN
          state_d = TRAIL;
          hcnt_d  = '0;
`else
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
`endif
        end else if (hcnt_hit) begin
          sclk_d = ~sclk_q;
          ecnt_d = ecnt_q + ECNT_ONE;
          hcnt_d = '0;
          if (cpha_q) begin
            shift_d  = lead_edge;
            sample_d = ~lead_edge;
          end else begin
            shift_d  = ~lead_edge & ~last_edge;
            sample_d = lead_edge;
          end
        end else begin
          hcnt_d = hcnt_q + HCNT_ONE;
        end
      end
`ifdef SPI_SCLK_CS_GUARD_EN
      TRAIL: begin
        if (hcnt_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HCNT_ONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
        hcnt_d  = '0;
        ecnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      nbits_q  <= '0;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      nbits_q  <= nbits_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign shift_en  = shift_q;
  assign sample_en = sample_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed testbench for spi_sclk_engine. Each frame is traced cycle by
// cycle (cycle 0 = the cycle start is high) and compared against timing
// derived from the frame parameters.
module tb_spi_sclk_engine;

`ifdef SPI_SCLK_CS_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       aclk;
  logic       aresetn;
  logic       start;
  logic       cpol;
  logic       cpha;
  logic [7:0] div;
  logic [5:0] nbits;
  logic       sclk;
  logic       cs_n;
  logic       shift_en;
  logic       sample_en;
  logic       busy;
  logic       done;

  int n_assert;
  int n_fail;

  logic tr_sclk   [0:255];
  logic tr_cs_n   [0:255];
  logic tr_shift  [0:255];
  logic tr_sample [0:255];
  logic tr_busy   [0:255];
  logic tr_done   [0:255];

  spi_sclk_engine #(.DIV_WIDTH(8), .CNT_WIDTH(6)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .div       (div),
    .nbits     (nbits),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .shift_en  (shift_en),
    .sample_en (sample_en),
    .busy      (busy),
    .done      (done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cap(input int c);
    tr_sclk[c]   = sclk;
    tr_cs_n[c]   = cs_n;
    tr_shift[c]  = shift_en;
    tr_sample[c] = sample_en;
    tr_busy[c]   = busy;
    tr_done[c]   = done;
  endtask

  // Expected frame timing: first edge, edge period and done cycle.
  task automatic timing(input int p_div, input int p_nbits,
                        output int first, output int last, output int done_c);
    int lead;
    int per;
    per  = p_div + 1;
    lead = GUARD ? per : 0;
    if (p_nbits == 0) begin
      first  = 1 << 20;
      last   = -1;
      done_c = 1;
    end else begin
      first  = 2 + lead + p_div;
      last   = first + (2 * p_nbits - 1) * per;
      done_c = last + 1 + (GUARD ? per : 0);
    end
  endtask

  // Issue one frame and trace it; extra start pulses at cycles s1/s2, and
  // optionally disturb cpha/div/nbits mid-frame.
  task automatic run_frame(input logic p_cpol, input logic p_cpha, input int p_div,
                           input int p_nbits, input int s1, input int s2,
                           input bit scramble);
    int first, last, done_c, ncyc;
    logic [31:0] dv, nv;
    timing(p_div, p_nbits, first, last, done_c);
    ncyc = done_c + 3;
    dv = p_div;
    nv = p_nbits;
    @(negedge aclk);
    cpol  = p_cpol;
    cpha  = p_cpha;
    div   = dv[7:0];
    nbits = nv[5:0];
    repeat (2) @(negedge aclk);
    start = 1'b1;
    cap(0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge aclk);
      #1;
      cap(c);
      start = ((c + 1) == s1) || ((c + 1) == s2);
      if (scramble && c == 5) begin
        cpha  = ~p_cpha;
        div   = 8'd5;
        nbits = 6'd1;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic p_cpol, input logic p_cpha,
                             input int p_div, input int p_nbits);
    int first, last, done_c, per, lead, k, nshift, nsample, nedges;
    logic edge_now, e_shift, e_sample, in_frame;
    timing(p_div, p_nbits, first, last, done_c);
    per     = p_div + 1;
    lead    = GUARD ? per : 0;
    nshift  = 0;
    nsample = 0;
    nedges  = 0;
    for (int c = 0; c <= done_c + 3; c++) begin
      edge_now = (c >= first) && (c <= last) && (((c - first) % per) == 0);
      k        = edge_now ? (c - first) / per : 0;
      if (edge_now) nedges++;
      in_frame = (p_nbits != 0) && (c >= 1) && (c < done_c);
      if (p_cpha) begin
        e_shift  = edge_now && (k % 2 == 0);
        e_sample = edge_now && (k % 2 == 1);
      end else begin
        e_shift  = ((p_nbits != 0) && (c == 1 + lead)) ||
                   (edge_now && (k % 2 == 1) && (k != 2 * p_nbits - 1));
        e_sample = edge_now && (k % 2 == 0);
      end
      if (tr_shift[c] === 1'b1) nshift++;
      if (tr_sample[c] === 1'b1) nsample++;
      chk($sformatf("%s c%0d sclk", tag, c), 32'(tr_sclk[c]), 32'(p_cpol ^ nedges[0]));
      chk($sformatf("%s c%0d cs_n", tag, c), 32'(tr_cs_n[c]), 32'(!in_frame));
      chk($sformatf("%s c%0d busy", tag, c), 32'(tr_busy[c]), 32'(in_frame));
      chk($sformatf("%s c%0d done", tag, c), 32'(tr_done[c]), 32'(c == done_c));
      chk($sformatf("%s c%0d shift_en", tag, c), 32'(tr_shift[c]), 32'(e_shift));
      chk($sformatf("%s c%0d sample_en", tag, c), 32'(tr_sample[c]), 32'(e_sample));
    end
    chk({tag, " shift_count"}, 32'(nshift), 32'(p_nbits));
    chk({tag, " sample_count"}, 32'(nsample), 32'(p_nbits));
  endtask

  initial begin
    int bad;
    logic prev_sclk;
    n_assert = 0;
    n_fail   = 0;
    aresetn  = 1'b0;
    start    = 1'b0;
    cpol     = 1'b1;
    cpha     = 1'b0;
    div      = 8'd0;
    nbits    = 6'd8;

    // Reset values, with cpol=1 so sclk reset value is distinguishable.
    repeat (3) @(posedge aclk);
    #1;
    chk("rst sclk", 32'(sclk), 32'd0);
    chk("rst cs_n", 32'(cs_n), 32'd1);
    chk("rst shift_en", 32'(shift_en), 32'd0);
    chk("rst sample_en", 32'(sample_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("idle sclk follows cpol=1", 32'(sclk), 32'd1);
    @(negedge aclk);
    cpol = 1'b0;
    #1;
    chk("idle sclk lag before edge", 32'(sclk), 32'd1);
    @(posedge aclk);
    #1;
    chk("idle sclk follows cpol=0", 32'(sclk), 32'd0);
    chk("idle cs_n without start", 32'(cs_n), 32'd1);

    // Basic mode 0 frame, div=0, nbits=8.
    run_frame(1'b0, 1'b0, 0, 8, 0, 0, 1'b0);
    check_frame("m0_d0_n8", 1'b0, 1'b0, 0, 8);

    // Mode 3 frame, div=2, nbits=4.
    run_frame(1'b1, 1'b1, 2, 4, 0, 0, 1'b0);
    check_frame("m3_d2_n4", 1'b1, 1'b1, 2, 4);

    // Empty frame.
    run_frame(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    check_frame("n0", 1'b0, 1'b0, 0, 0);

    // Start re-pulsed during busy and during the done cycle is ignored.
    begin
      int f, l, dc;
      timing(0, 2, f, l, dc);
      run_frame(1'b0, 1'b0, 0, 2, 3, dc, 1'b0);
      check_frame("restart_ignored", 1'b0, 1'b0, 0, 2);
    end

    // Inputs disturbed mid-frame have no effect on the frame.
    run_frame(1'b0, 1'b1, 1, 3, 0, 0, 1'b1);
    check_frame("inputs_frozen", 1'b0, 1'b1, 1, 3);

    // Maximum nbits: edge counter must not wrap.
    run_frame(1'b0, 1'b0, 0, 63, 0, 0, 1'b0);
    check_frame("nbits_max", 1'b0, 1'b0, 0, 63);

    // Reset asserted mid-frame at cycle 10.
    @(negedge aclk);
    cpol  = 1'b0;
    cpha  = 1'b0;
    div   = 8'd0;
    nbits = 6'd8;
    repeat (2) @(negedge aclk);
    start = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge aclk);
      #1;
    end
    chk("midrst busy before reset", 32'(busy), 32'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst sclk", 32'(sclk), 32'd0);
    chk("midrst cs_n", 32'(cs_n), 32'd1);
    chk("midrst shift_en", 32'(shift_en), 32'd0);
    chk("midrst sample_en", 32'(sample_en), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    bad = 0;
    prev_sclk = sclk;
    for (int c = 0; c < 30; c++) begin
      @(posedge aclk);
      #1;
      if (done !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0 || sclk !== prev_sclk ||
          shift_en !== 1'b0 || sample_en !== 1'b0) bad++;
      prev_sclk = sclk;
    end
    chk("quiet after reset release", 32'(bad), 32'd0);
    run_frame(1'b0, 1'b0, 0, 8, 0, 0, 1'b0);
    check_frame("after_reset", 1'b0, 1'b0, 0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_sclk_engine.md
SPI_SCLK_ENGINE -- requirements
Module: spi_sclk_engine

Interface
REQ-001 Parameter DIV_WIDTH, default 8: width of the half-period divider input.
REQ-002 Parameter CNT_WIDTH, default 6: width of the frame bit-count input.
REQ-003 aclk  in  1  single clock; all logic SHALL be synchronous to the rising edge of aclk.
REQ-004 aresetn  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  frame request, sampled only in IDLE.
REQ-006 cpol  in  1  SPI clock polarity.
REQ-007 cpha  in  1  SPI clock phase.
REQ-008 div  in  DIV_WIDTH  half-period of sclk is div+1 aclk cycles.
REQ-009 nbits  in  CNT_WIDTH  bits per frame.
REQ-010 sclk  out  1  generated SPI clock, registered.
REQ-011 cs_n  out  1  chip select, active-low, registered.
REQ-012 shift_en  out  1  one-cycle strobe: drive next data bit.
REQ-013 sample_en  out  1  one-cycle strobe: capture MISO bit.
REQ-014 busy  out  1  frame in progress.
REQ-015 done  out  1  one-cycle frame-complete strobe.

Function
REQ-016 FSM states SHALL be IDLE, LEAD, RUN, TRAIL and DONE; LEAD and TRAIL exist only per REQ-031.
REQ-017 In IDLE, start=1 at cycle T with nbits!=0 SHALL latch cpol, cpha, div and nbits; at T+1 busy=1, cs_n=0 and the FSM enters RUN (or LEAD).
REQ-018 start with nbits=0 SHALL produce no sclk edge and no cs_n assertion, with done=1 at T+1 only.
REQ-019 start while busy=1 or done=1 SHALL be ignored; input changes while busy SHALL have no effect on the frame in progress.
REQ-020 In IDLE, sclk SHALL equal cpol registered (one-cycle lag).
REQ-021 A half-period counter SHALL count div+1 cycles; each expiry in RUN toggles sclk; a frame SHALL contain exactly 2*nbits edges.
REQ-022 cpha=0: shift_en SHALL pulse in the RUN entry cycle and on trailing edges 1..nbits-1; sample_en SHALL pulse on every leading edge.
REQ-023 cpha=1: shift_en SHALL pulse on every leading edge; sample_en SHALL pulse on every trailing edge.
REQ-024 Each strobe SHALL assert in the same cycle as the sclk register change it belongs to; each frame yields exactly nbits shift_en and nbits sample_en pulses.
REQ-025 The cycle after the last edge, without the REQ-031 guard, SHALL enter DONE: done=1, busy=0, cs_n=1 for one cycle, then IDLE.
REQ-026 div=0 SHALL give sclk = aclk/2 with no gap between edges.
REQ-027 The edge counter SHALL be CNT_WIDTH+1 bits wide; nbits at its maximum value SHALL NOT wrap.

Reset
REQ-028 aresetn=0 SHALL asynchronously force IDLE: sclk=0, cs_n=1, shift_en=0, sample_en=0, busy=0, done=0, counters=0.
REQ-029 Reset mid-frame SHALL abort the frame with no done pulse; after release, sclk follows cpol per REQ-020.
REQ-030 Reset release SHALL require a start to begin activity.

Configuration
REQ-031 Macro SPI_SCLK_CS_GUARD_EN defined: LEAD SHALL hold cs_n=0 and sclk idle for div+1 cycles before RUN, with the cpha=0 initial shift_en issued on RUN entry; TRAIL SHALL hold cs_n=0 for div+1 cycles after the last edge before DONE.
REQ-032 Macro undefined: LEAD and TRAIL SHALL NOT exist, and timing SHALL be per REQ-017/REQ-025.

Verification
REQ-033 No guard, cpol=0, cpha=0, div=0, nbits=8, start at cycle 0 -> busy and cs_n=0 from cycle 1; shift_en at 1; sclk edges at 2..17; done at 18; 8 sample_en, 8 shift_en.
REQ-034 No guard, cpol=1, cpha=1, div=2, nbits=4 -> sclk idles 1; edges every 3 cycles at 4,7,...,25; shift_en on falling edges; sample_en on rising edges; done at 26.
REQ-035 start pulsed during busy and again during done -> ignored; exactly one frame, one done.
REQ-036 aresetn low at cycle 10 of the REQ-033 frame -> all outputs at reset values immediately; no done; a new start after release gives a full correct frame.
REQ-037 Guard build, REQ-033 stimulus -> cs_n=0 from 1; first edge at 3; last edge at 18; done at 20.
REQ-038 nbits=0 -> done at cycle 1; cs_n stays 1; no strobes or sclk edges.
